// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    localparam logic [1:0] MEMRW_READ  = 2'b10;
    localparam logic [1:0] MEMRW_WRITE = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_I_WAIT,
        ST_D_WAIT,
        ST_I_DISCARD
    } arb_state_e;

endpackage

// File: rtl/mem_arb_resp_buf.sv
// One-entry response buffer: holds a completed memory result until the pipeline consumes it.
module mem_arb_resp_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          consume,
    input  logic          flush,
    input  logic [DW-1:0] load_data,
    output logic          valid,
    output logic [DW-1:0] data
);

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            // A result loaded while the pipeline advances is consumed immediately.
            valid <= (valid | load) & ~consume & ~flush;
            if (load) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and data access;
// data has fixed priority, results are buffered until the pipeline advances.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pipe_advance,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_flush,
    output logic [DW-1:0]   i_rdata,
    output logic            iready_n,
    input  logic [1:0]      d_memrw,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_wstrb,
    output logic [DW-1:0]   d_rdata,
    output logic            dready_n,
    output logic            dbusy,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wstrb,
    input  logic [DW-1:0]   mem_rdata,
    input  logic            mem_ack
);

    arb_state_e    state, state_next;
    logic          issue_d, issue_i;
    logic          d_pend, i_pend;
    logic          i_ack, d_ack;
    logic          i_buf_valid, d_buf_valid;
    logic [DW-1:0] i_buf_data, d_buf_data;

    assign d_pend = (d_memrw != 2'b00) && !d_buf_valid;
    assign i_pend = i_req && !i_buf_valid;

    // A fetch ack coinciding with a flush is stale and treated like a discarded one.
    assign i_ack = (state == ST_I_WAIT) && mem_ack && !i_flush && !rst;
    assign d_ack = (state == ST_D_WAIT) && mem_ack && !rst;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        issue_d    = 1'b0;
        issue_i    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (d_pend) begin
                    issue_d    = 1'b1;
                    state_next = ST_D_WAIT;
                end else if (i_pend) begin
                    issue_i    = 1'b1;
                    state_next = ST_I_WAIT;
                end
            end
            ST_I_WAIT: begin
                if (mem_ack)      state_next = ST_IDLE;
                else if (i_flush) state_next = ST_I_DISCARD;
            end
            ST_D_WAIT:    if (mem_ack) state_next = ST_IDLE;
            ST_I_DISCARD: if (mem_ack) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state   <= state_next;
            mem_req <= (state_next != ST_IDLE);
            if (issue_d) begin
                mem_we    <= (d_memrw == MEMRW_WRITE);
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_wstrb <= (d_memrw == MEMRW_WRITE) ? d_wstrb : '0;
            end else if (issue_i) begin
                mem_we    <= 1'b0;
                mem_addr  <= i_addr;
                mem_wstrb <= '0;
            end
        end
    end

    mem_arb_resp_buf #(.DW(DW)) u_i_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (i_ack),
        .consume   (pipe_advance),
        .flush     (i_flush),
        .load_data (mem_rdata),
        .valid     (i_buf_valid),
        .data      (i_buf_data)
    );

    mem_arb_resp_buf #(.DW(DW)) u_d_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (d_ack),
        .consume   (pipe_advance),
        .flush     (1'b0),
        .load_data (mem_rdata),
        .valid     (d_buf_valid),
        .data      (d_buf_data)
    );

    assign iready_n = i_req & ~(i_buf_valid | i_ack);
    assign dready_n = d_memrw[1] & ~(d_buf_valid | (d_ack & ~mem_we));
    assign dbusy    = (d_memrw == MEMRW_WRITE) & ~(d_buf_valid | (d_ack & mem_we));
    assign i_rdata  = i_ack ? mem_rdata : i_buf_data;
    assign d_rdata  = d_ack ? mem_rdata : d_buf_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, pipe_advance, i_req, i_flush, mem_ack;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic [1:0]    d_memrw;
    logic [3:0]    d_wstrb, mem_wstrb;
    logic          iready_n, dready_n, dbusy, mem_req, mem_we;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_advance (pipe_advance),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_flush      (i_flush),
        .i_rdata      (i_rdata),
        .iready_n     (iready_n),
        .d_memrw      (d_memrw),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_wstrb      (d_wstrb),
        .d_rdata      (d_rdata),
        .dready_n     (dready_n),
        .dbusy        (dbusy),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: one in-flight transaction record plus the two result buffers.
    bit          m_known = 1'b0;
    bit          m_busy, m_data, m_we, m_stale;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          m_ib_v, m_db_v;
    logic [31:0] m_ib_d, m_db_d;

    always @(negedge clk) begin
        bit f_done, d_done, ib_old, db_old, e_ir, e_dr, e_db;
        f_done = m_busy && !m_data && !m_stale && mem_ack && !i_flush && !rst;
        d_done = m_busy && m_data && mem_ack && !rst;
        if (m_known) begin
            e_ir = i_req && !(m_ib_v || f_done);
            e_dr = d_memrw[1] && !(m_db_v || (d_done && !m_we));
            e_db = (d_memrw == 2'b01) && !(m_db_v || (d_done && m_we));
            check("mem_req", 32'(mem_req), 32'(m_busy));
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_addr", mem_addr, m_addr);
            check("iready_n", 32'(iready_n), 32'(e_ir));
            check("dready_n", 32'(dready_n), 32'(e_dr));
            check("dbusy", 32'(dbusy), 32'(e_db));
            if (m_busy && m_we) begin
                check("mem_wdata", mem_wdata, m_wdata);
                check("mem_wstrb", 32'(mem_wstrb), 32'(m_wstrb));
            end
            if (i_req && !e_ir) check("i_rdata", i_rdata, f_done ? mem_rdata : m_ib_d);
            if (d_memrw[1] && !e_dr) check("d_rdata", d_rdata, d_done ? mem_rdata : m_db_d);
        end
        if (rst) begin
            m_known = 1'b1;
            m_busy = 0; m_data = 0; m_we = 0; m_stale = 0;
            m_addr = '0; m_wdata = '0; m_wstrb = '0;
            m_ib_v = 0; m_db_v = 0; m_ib_d = '0; m_db_d = '0;
        end else if (m_known) begin
            ib_old = m_ib_v;
            db_old = m_db_v;
            if (f_done) begin
                m_ib_v = !pipe_advance;
                m_ib_d = mem_rdata;
            end else if (pipe_advance || i_flush) begin
                m_ib_v = 1'b0;
            end
            if (d_done) begin
                m_db_v = !pipe_advance;
                m_db_d = mem_rdata;
            end else if (pipe_advance) begin
                m_db_v = 1'b0;
            end
            if (m_busy) begin
                if (mem_ack) m_busy = 1'b0;
                else if (!m_data && i_flush) m_stale = 1'b1;
            end else if (d_memrw != 2'b00 && !db_old) begin
                m_busy = 1; m_data = 1; m_stale = 0;
                m_we = (d_memrw == 2'b01);
                m_addr = d_addr;
                m_wdata = d_wdata;
                m_wstrb = d_wstrb;
            end else if (i_req && !ib_old) begin
                m_busy = 1; m_data = 0; m_stale = 0; m_we = 0;
                m_addr = i_addr;
            end
        end
    end

    initial begin
        rst = 1; pipe_advance = 0; i_req = 0; i_addr = '0; i_flush = 0;
        d_memrw = 2'b00; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_rdata = '0; mem_ack = 0;
        tick(); tick();
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_mem_wstrb", 32'(mem_wstrb), 0);
        rst = 0;
        tick();

        // Fetch alone, ack three cycles after mem_req, then held buffer blocks re-issue.
        i_req = 1; i_addr = 32'h100;
        tick();
        check("t1_req", 32'(mem_req), 1);
        check("t1_addr", mem_addr, 32'h100);
        tick(); tick();
        mem_ack = 1; mem_rdata = 32'hDEADBEEF; #1;
        check("t1_iready_n", 32'(iready_n), 0);
        check("t1_i_rdata", i_rdata, 32'hDEADBEEF);
        tick();
        mem_ack = 0; mem_rdata = '0;
        repeat (5) begin
            check("t4_no_reissue", 32'(mem_req), 0);
            tick();
        end
        check("t4_buf_rdata", i_rdata, 32'hDEADBEEF);
        pipe_advance = 1;
        tick();
        pipe_advance = 0;
        tick();
        check("t4_reissue", 32'(mem_req), 1);
        mem_ack = 1;
        tick();
        mem_ack = 0; i_req = 0; pipe_advance = 1;
        tick();
        pipe_advance = 0;

        // Fetch and load together: data first, fetch follows after one idle cycle.
        i_req = 1; i_addr = 32'h200; d_memrw = 2'b10; d_addr = 32'h8000;
        tick();
        check("t2_first_addr", mem_addr, 32'h8000);
        check("t2_iready_n_a", 32'(iready_n), 1);
        tick();
        mem_ack = 1; mem_rdata = 32'hCAFE0001; #1;
        check("t2_dready_n", 32'(dready_n), 0);
        check("t2_d_rdata", d_rdata, 32'hCAFE0001);
        check("t2_iready_n_b", 32'(iready_n), 1);
        tick();
        mem_ack = 0; #1;
        check("t2_idle_gap", 32'(mem_req), 0);
        check("t2_iready_n_c", 32'(iready_n), 1);
        tick();
        check("t2_second_req", 32'(mem_req), 1);
        check("t2_second_addr", mem_addr, 32'h200);
        mem_ack = 1;
        tick();
        mem_ack = 0; i_req = 0; d_memrw = 2'b00; pipe_advance = 1;
        tick();
        pipe_advance = 0;

        // Store: dbusy until ack, no re-issue while the done flag is held.
        d_memrw = 2'b01; d_addr = 32'h40; d_wdata = 32'h12345678; d_wstrb = 4'hF; #1;
        check("t3_dbusy_pre", 32'(dbusy), 1);
        tick();
        check("t3_we", 32'(mem_we), 1);
        check("t3_wdata", mem_wdata, 32'h12345678);
        check("t3_wstrb", 32'(mem_wstrb), 32'hF);
        mem_ack = 1; #1;
        check("t3_dbusy_ack", 32'(dbusy), 0);
        tick();
        mem_ack = 0;
        repeat (3) begin
            check("t3_no_reissue", 32'(mem_req), 0);
            check("t3_dbusy_held", 32'(dbusy), 0);
            tick();
        end
        d_memrw = 2'b00; pipe_advance = 1;
        tick();
        pipe_advance = 0;

        // Flush during the fetch wait: ack swallowed, new address fetched afterwards.
        i_req = 1; i_addr = 32'h300;
        tick();
        check("t5_addr_old", mem_addr, 32'h300);
        i_flush = 1; i_addr = 32'h400;
        tick();
        i_flush = 0; mem_ack = 1; mem_rdata = 32'hBAD0BAD0; #1;
        check("t5_iready_n", 32'(iready_n), 1);
        tick();
        mem_ack = 0;
        tick();
        check("t5_new_req", 32'(mem_req), 1);
        check("t5_new_addr", mem_addr, 32'h400);
        mem_ack = 1;
        tick();
        mem_ack = 0; i_req = 0; pipe_advance = 1;
        tick();
        pipe_advance = 0;

        // Reset while a load waits; the late ack is ignored.
        d_memrw = 2'b10; d_addr = 32'h500;
        tick();
        check("t6_req", 32'(mem_req), 1);
        rst = 1;
        tick();
        rst = 0; mem_ack = 1; #1;
        check("t6_req_dropped", 32'(mem_req), 0);
        check("t6_dready_n", 32'(dready_n), 1);
        tick();
        mem_ack = 0;
        check("t6_reissue", 32'(mem_req), 1);
        mem_ack = 1;
        tick();
        mem_ack = 0; d_memrw = 2'b00; pipe_advance = 1;
        tick();
        pipe_advance = 0;

        // Randomized traffic, checked cycle by cycle against the model.
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(99) == 0);
            pipe_advance = ($urandom_range(2) == 0);
            if ($urandom_range(3) == 0) begin
                i_req  = 1'($urandom_range(1));
                i_addr = 32'($urandom_range(15)) << 2;
            end
            i_flush = ($urandom_range(9) == 0);
            if (i_flush) i_addr = $urandom;
            if ($urandom_range(3) == 0) begin
                d_memrw = 2'($urandom_range(3));
                d_addr  = $urandom;
                d_wdata = $urandom;
                d_wstrb = 4'($urandom_range(15));
            end
            mem_ack   = mem_req ? ($urandom_range(2) == 0) : ($urandom_range(15) == 0);
            mem_rdata = $urandom;
            tick();
        end

        rst = 0; mem_ack = 0; i_req = 0; d_memrw = 2'b00; i_flush = 0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
